vx_axi_mem_slave: RTL and testbench

- On-chip AXI4 slave memory that consumes the Vortex AXI master interface (AW/W/B/AR/R) directly; used as the simulation and FPGA-bringup backing store.
- Independent read and write engines on a dual-port word array.
- Only INCR bursts are supported.
- Lock, cache, prot, qos, size and burst inputs are not present: full-width beats only; the parent leaves those master outputs unconnected.

---
 rtl/vx_axi_mem_slave.sv | 224 ++++++++++++++++++++++
 tb/tb_vx_axi_mem_slave.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_axi_mem_slave.sv
// AXI4 slave backing store: independent write and read engines over a
// byte-enabled word array. INCR bursts, full-width beats only.
module vx_axi_mem_slave #(
    parameter int                        AXI_DATA_WIDTH   = 512,
    parameter int                        AXI_ADDR_WIDTH   = 32,
    parameter int                        AXI_TID_WIDTH    = 8,
    parameter int                        MEM_WORDS        = 4096,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR        = '0,
    parameter int                        AXI_STROBE_WIDTH = AXI_DATA_WIDTH / 8
) (
    input  logic                        clk,
    input  logic                        reset,

    input  logic [AXI_TID_WIDTH-1:0]    s_axi_awid,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]                  s_axi_awlen,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,

    input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [AXI_STROBE_WIDTH-1:0] s_axi_wstrb,
    input  logic                        s_axi_wlast,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,

    output logic [AXI_TID_WIDTH-1:0]    s_axi_bid,
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,

    input  logic [AXI_TID_WIDTH-1:0]    s_axi_arid,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]                  s_axi_arlen,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,

    output logic [AXI_TID_WIDTH-1:0]    s_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rlast,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready
);

    localparam int SHIFT = $clog2(AXI_STROBE_WIDTH);
    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    // One extra address bit so a long burst near the top of the map cannot wrap.
    localparam int EA    = AXI_ADDR_WIDTH + 1;

    localparam logic [EA-1:0] BASE_EXT   = {1'b0, BASE_ADDR};
    localparam logic [EA-1:0] MEM_BYTES  = EA'(MEM_WORDS) << SHIFT;
    localparam logic [EA-1:0] BEAT_BYTES = EA'(AXI_STROBE_WIDTH);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_e;

    logic [AXI_DATA_WIDTH-1:0] mem_q [MEM_WORDS];

    // ---------------- write engine ----------------
    wstate_e                  w_state_q;
    logic [AXI_TID_WIDTH-1:0] w_id_q, bid_q;
    logic [EA-1:0]            w_addr_q;
    logic [7:0]               w_len_q, w_cnt_q;
    logic [1:0]               w_err_q, w_err_d, bresp_q;
    logic                     awready_q, wready_q, bvalid_q;

    logic [EA:0]              w_rel;
    logic                     w_in, w_last_beat, w_fire, w_we;
    logic [IDX_W-1:0]         w_idx;

    // A negative offset (below BASE_ADDR) shows up in the extra top bit.
    assign w_rel       = {1'b0, w_addr_q} - {1'b0, BASE_EXT};
    assign w_in        = !w_rel[EA] && (w_rel[EA-1:0] < MEM_BYTES);
    assign w_idx       = w_rel[SHIFT +: IDX_W];
    assign w_last_beat = (w_cnt_q == w_len_q);
    assign w_fire      = wready_q && s_axi_wvalid;
    assign w_we        = w_fire && w_in;

    always_comb begin
        w_err_d = w_err_q;
        if (!w_in)
            w_err_d = RESP_DECERR;
        else if ((s_axi_wlast != w_last_beat) && (w_err_q != RESP_DECERR))
            w_err_d = RESP_SLVERR;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            bid_q     <= '0;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= RESP_OKAY;
        end else begin
            case (w_state_q)
                W_IDLE: if (s_axi_awvalid && awready_q) begin
                    w_id_q    <= s_axi_awid;
                    w_addr_q  <= {1'b0, s_axi_awaddr};
                    w_len_q   <= s_axi_awlen;
                    w_cnt_q   <= '0;
                    w_err_q   <= RESP_OKAY;
                    awready_q <= 1'b0;
                    wready_q  <= 1'b1;
                    w_state_q <= W_DATA;
                end
                W_DATA: if (w_fire) begin
                    w_err_q  <= w_err_d;
                    w_cnt_q  <= w_cnt_q + 8'd1;
                    w_addr_q <= w_addr_q + BEAT_BYTES;
                    // Burst length comes from AWLEN; wlast is only checked.
                    if (w_last_beat) begin
                        wready_q  <= 1'b0;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= w_err_d;
                        bid_q     <= w_id_q;
                        w_state_q <= W_RESP;
                    end
                end
                W_RESP: if (s_axi_bready) begin
                    bvalid_q  <= 1'b0;
                    awready_q <= 1'b1;
                    w_state_q <= W_IDLE;
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < AXI_STROBE_WIDTH; b++) begin
            if (w_we && s_axi_wstrb[b])
                mem_q[w_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
        end
    end

    // ---------------- read engine ----------------
    rstate_e                   r_state_q;
    logic [AXI_TID_WIDTH-1:0]  r_id_q, rid_q;
    logic [EA-1:0]             r_addr_q;
    logic [7:0]                r_len_q, r_cnt_q;
    logic                      arready_q, rvalid_q, rlast_q;
    logic [1:0]                rresp_q;
    logic [AXI_DATA_WIDTH-1:0] rdata_q;

    logic [EA:0]               r_rel;
    logic                      r_in;
    logic [IDX_W-1:0]          r_idx;

    assign r_rel = {1'b0, r_addr_q} - {1'b0, BASE_EXT};
    assign r_in  = !r_rel[EA] && (r_rel[EA-1:0] < MEM_BYTES);
    assign r_idx = r_rel[SHIFT +: IDX_W];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rid_q     <= '0;
            rdata_q   <= '0;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: if (s_axi_arvalid && arready_q) begin
                    r_id_q    <= s_axi_arid;
                    r_addr_q  <= {1'b0, s_axi_araddr};
                    r_len_q   <= s_axi_arlen;
                    r_cnt_q   <= '0;
                    arready_q <= 1'b0;
                    r_state_q <= R_FETCH;
                end
                // Array read lands here; a same-cycle write is seen next time.
                R_FETCH: begin
                    rvalid_q  <= 1'b1;
                    rid_q     <= r_id_q;
                    rlast_q   <= (r_cnt_q == r_len_q);
                    rdata_q   <= r_in ? mem_q[r_idx] : '0;
                    rresp_q   <= r_in ? RESP_OKAY : RESP_DECERR;
                    r_state_q <= R_DATA;
                end
                R_DATA: if (s_axi_rready) begin
                    rvalid_q <= 1'b0;
                    rlast_q  <= 1'b0;
                    if (rlast_q) begin
                        arready_q <= 1'b1;
                        r_state_q <= R_IDLE;
                    end else begin
                        r_cnt_q   <= r_cnt_q + 8'd1;
                        r_addr_q  <= r_addr_q + BEAT_BYTES;
                        r_state_q <= R_FETCH;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_bid     = bid_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rlast   = rlast_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rid     = rid_q;
    assign s_axi_rdata   = rdata_q;

endmodule

// File: tb/tb_vx_axi_mem_slave.sv
// Directed bench for vx_axi_mem_slave: vector table of bursts plus hand-written
// reset, backpressure and concurrency sequences, checked against a word model.
module tb_vx_axi_mem_slave;

    localparam int DW  = 512;
    localparam int SW  = DW / 8;
    localparam int MW  = 512;
    localparam int TMO = 1000;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [7:0]      s_axi_awid = '0;
    logic [31:0]     s_axi_awaddr = '0;
    logic [7:0]      s_axi_awlen = '0;
    logic            s_axi_awvalid = 1'b0;
    logic            s_axi_awready;
    logic [DW-1:0]   s_axi_wdata = '0;
    logic [SW-1:0]   s_axi_wstrb = '0;
    logic            s_axi_wlast = 1'b0;
    logic            s_axi_wvalid = 1'b0;
    logic            s_axi_wready;
    logic [7:0]      s_axi_bid;
    logic [1:0]      s_axi_bresp;
    logic            s_axi_bvalid;
    logic            s_axi_bready = 1'b0;
    logic [7:0]      s_axi_arid = '0;
    logic [31:0]     s_axi_araddr = '0;
    logic [7:0]      s_axi_arlen = '0;
    logic            s_axi_arvalid = 1'b0;
    logic            s_axi_arready;
    logic [7:0]      s_axi_rid;
    logic [DW-1:0]   s_axi_rdata;
    logic [1:0]      s_axi_rresp;
    logic            s_axi_rlast;
    logic            s_axi_rvalid;
    logic            s_axi_rready = 1'b0;

    always #5 clk = ~clk;

    vx_axi_mem_slave #(.MEM_WORDS(MW)) dut (
        .clk(clk), .reset(reset),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic          saw_b = 1'b0;
    logic [DW-1:0] mdl     [MW];
    logic [DW-1:0] rd_data [256];
    logic [1:0]    rd_resp [256];
    logic          rd_last [256];
    logic [7:0]    rd_id   [256];

    typedef struct {
        bit         wr;
        logic [7:0] id;
        logic [31:0] addr;
        int         len;
        logic [7:0] seed;
        int         pbeat;     // beat written with wstrb=0x0F, -1 none
        int         wl_at;     // extra early wlast beat, -1 none
        logic [1:0] exp_resp;  // bresp, or rresp of first read beat
    } vec_t;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timeout after %0d cycles", name, TMO);
    endtask

    function automatic logic [DW-1:0] pat(input logic [7:0] seed, input int beat);
        logic [DW-1:0] p;
        for (int b = 0; b < SW; b++) p[b*8 +: 8] = (seed + 8'(beat * 37)) ^ 8'(b);
        return p;
    endfunction

    function automatic bit in_rng(input logic [31:0] addr, input int beat);
        longint unsigned w;
        w = longint'(addr >> 6) + longint'(beat);
        return w < longint'(MW);
    endfunction

    task automatic axi_write(input logic [7:0] id, input logic [31:0] addr, input int len,
                             input logic [7:0] seed, input int pbeat, input int wl_at,
                             output logic [1:0] resp, output logic [7:0] bid);
        int t;
        logic [DW-1:0] d;
        logic [SW-1:0] st;
        resp = 2'bxx;
        bid  = 'x;
        @(negedge clk);
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = 8'(len); s_axi_awvalid = 1'b1;
        t = 0;
        while (!s_axi_awready && t < TMO) begin @(negedge clk); t++; end
        if (t >= TMO) tmo("aw_handshake");
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            d  = pat(seed, i);
            st = (i == pbeat) ? SW'(64'h0F) : '1;
            s_axi_wdata = d; s_axi_wstrb = st; s_axi_wlast = (i == len) || (i == wl_at);
            s_axi_wvalid = 1'b1;
            t = 0;
            while (!s_axi_wready && t < TMO) begin @(negedge clk); t++; end
            if (t >= TMO) begin tmo("w_handshake"); break; end
            if (in_rng(addr, i))
                for (int b = 0; b < SW; b++)
                    if (st[b]) mdl[int'(addr >> 6) + i][b*8 +: 8] = d[b*8 +: 8];
            @(negedge clk);
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        s_axi_bready = 1'b1;
        t = 0;
        while (!s_axi_bvalid && t < TMO) begin @(negedge clk); t++; end
        if (t >= TMO) tmo("b_wait");
        else begin resp = s_axi_bresp; bid = s_axi_bid; end
        @(negedge clk);
        s_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] id, input logic [31:0] addr, input int len,
                            input int stall_beat, output int n, output int lat);
        int t;
        n = 0;
        @(negedge clk);
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = 8'(len);
        s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
        t = 0;
        while (!s_axi_arready && t < TMO) begin @(negedge clk); t++; end
        if (t >= TMO) tmo("ar_handshake");
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        lat = 1;
        while (!s_axi_rvalid && lat < TMO) begin @(negedge clk); lat++; end
        for (int i = 0; i <= len; i++) begin
            t = 0;
            while (!s_axi_rvalid && t < TMO) begin @(negedge clk); t++; end
            if (t >= TMO) begin tmo("r_wait"); break; end
            rd_data[i] = s_axi_rdata; rd_resp[i] = s_axi_rresp;
            rd_last[i] = s_axi_rlast; rd_id[i]   = s_axi_rid;
            n = i + 1;
            if (i == stall_beat) begin
                s_axi_rready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    if (s_axi_bvalid) saw_b = 1'b1;
                    chk("stall_rvalid", DW'(s_axi_rvalid), DW'(1'b1));
                    chk("stall_rdata", s_axi_rdata, rd_data[i]);
                    chk("stall_rid", DW'(s_axi_rid), DW'(rd_id[i]));
                    chk("stall_rlast", DW'(s_axi_rlast), DW'(rd_last[i]));
                end
                s_axi_rready = 1'b1;
            end
            @(negedge clk);
        end
        s_axi_rready = 1'b0;
    endtask

    task automatic check_read(input logic [7:0] id, input logic [31:0] addr, input int len,
                              input int n, input int lat, input logic [1:0] exp0);
        bit ok;
        chk("r_latency", DW'(lat), DW'(2));
        if (n > 0) chk("r_resp_beat0", DW'(rd_resp[0]), DW'(exp0));
        for (int i = 0; i < n; i++) begin
            ok = in_rng(addr, i);
            chk($sformatf("r_data[%0d]@%0h", i, addr), rd_data[i], ok ? mdl[int'(addr >> 6) + i] : '0);
            chk($sformatf("r_resp[%0d]@%0h", i, addr), DW'(rd_resp[i]), DW'(ok ? 2'b00 : 2'b11));
            chk($sformatf("r_last[%0d]@%0h", i, addr), DW'(rd_last[i]), DW'(i == len));
            chk($sformatf("r_id[%0d]@%0h", i, addr), DW'(rd_id[i]), DW'(id));
        end
    endtask

    initial begin
        vec_t       vec [17];
        logic [1:0] resp, resp2;
        logic [7:0] bid, bid2;
        int         n, lat;

        vec[0]  = '{1'b1, 8'h11, 32'h0000_0040,   0, 8'hA5, -1, -1, 2'b00};
        vec[1]  = '{1'b0, 8'h22, 32'h0000_0040,   0, 8'h00, -1, -1, 2'b00};
        vec[2]  = '{1'b1, 8'h01, 32'h0000_0000,   1, 8'h0F, -1, -1, 2'b00};
        vec[3]  = '{1'b1, 8'h33, 32'h0000_0100,   3, 8'h10, -1, -1, 2'b00};
        vec[4]  = '{1'b1, 8'h34, 32'h0000_0100,   3, 8'h20,  2, -1, 2'b00};
        vec[5]  = '{1'b0, 8'h35, 32'h0000_0100,   3, 8'h00, -1, -1, 2'b00};
        vec[6]  = '{1'b1, 8'h44, 32'h0000_8000,   0, 8'hC0, -1, -1, 2'b11};
        vec[7]  = '{1'b0, 8'h45, 32'h0000_8000,   0, 8'h00, -1, -1, 2'b11};
        vec[8]  = '{1'b1, 8'h55, 32'h0000_0200,   1, 8'hB0, -1,  0, 2'b10};
        vec[9]  = '{1'b0, 8'h56, 32'h0000_0200,   1, 8'h00, -1, -1, 2'b00};
        vec[10] = '{1'b1, 8'h66, 32'h0000_7F80,   3, 8'hD0, -1, -1, 2'b11};
        vec[11] = '{1'b0, 8'h67, 32'h0000_7F80,   3, 8'h00, -1, -1, 2'b00};
        vec[12] = '{1'b0, 8'h02, 32'h0000_0000,   1, 8'h00, -1, -1, 2'b00};
        vec[13] = '{1'b1, 8'h68, 32'h0000_02C5,   0, 8'hE0, -1, -1, 2'b00};
        vec[14] = '{1'b0, 8'h69, 32'h0000_02C0,   0, 8'h00, -1, -1, 2'b00};
        vec[15] = '{1'b1, 8'h7A, 32'h0000_0000, 255, 8'h01, -1, -1, 2'b00};
        vec[16] = '{1'b0, 8'h7B, 32'h0000_0000, 255, 8'h00, -1, -1, 2'b00};

        // Asynchronous reset before any clock edge.
        #1 reset = 1'b0;
        #1;
        chk("rst_awready", DW'(s_axi_awready), DW'(1'b1));
        chk("rst_arready", DW'(s_axi_arready), DW'(1'b1));
        chk("rst_wready",  DW'(s_axi_wready),  DW'(1'b0));
        chk("rst_bvalid",  DW'(s_axi_bvalid),  DW'(1'b0));
        chk("rst_rvalid",  DW'(s_axi_rvalid),  DW'(1'b0));
        chk("rst_rlast",   DW'(s_axi_rlast),   DW'(1'b0));
        chk("rst_rdata",   s_axi_rdata,        '0);
        chk("rst_bid_bresp", DW'({s_axi_bid, s_axi_bresp}), '0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        foreach (vec[k]) begin
            if (vec[k].wr) begin
                axi_write(vec[k].id, vec[k].addr, vec[k].len, vec[k].seed,
                          vec[k].pbeat, vec[k].wl_at, resp, bid);
                chk($sformatf("bresp[v%0d]", k), DW'(resp), DW'(vec[k].exp_resp));
                chk($sformatf("bid[v%0d]", k), DW'(bid), DW'(vec[k].id));
            end else begin
                axi_read(vec[k].id, vec[k].addr, vec[k].len, -1, n, lat);
                check_read(vec[k].id, vec[k].addr, vec[k].len, n, lat, vec[k].exp_resp);
            end
            if (k == 5) begin
                chk("partial_low_bytes", DW'(rd_data[2][31:0]), DW'(pat(8'h20, 2)[31:0]));
                chk("partial_high_bytes", DW'(rd_data[2][63:32]), DW'(pat(8'h10, 2)[63:32]));
            end
            if (k == 1) chk("a5_byte0", DW'(rd_data[0][7:0]), DW'(8'hA5));
        end

        // Backpressure: stall beat 1 for 5 cycles while an unrelated write completes.
        axi_write(8'h60, 32'h1000, 3, 8'h60, -1, -1, resp, bid);
        chk("pre_bresp", DW'(resp), '0);
        saw_b = 1'b0;
        fork
            axi_read(8'h77, 32'h1000, 3, 1, n, lat);
            begin
                repeat (4) @(negedge clk);
                axi_write(8'h78, 32'h1400, 1, 8'h70, -1, -1, resp2, bid2);
            end
        join
        check_read(8'h77, 32'h1000, 3, n, lat, 2'b00);
        chk("conc_bresp", DW'(resp2), '0);
        chk("conc_bid", DW'(bid2), DW'(8'h78));
        chk("b_during_r_stall", DW'(saw_b), DW'(1'b1));
        axi_read(8'h79, 32'h1400, 1, -1, n, lat);
        check_read(8'h79, 32'h1400, 1, n, lat, 2'b00);

        // Reset mid-burst: one beat lands, then the burst is abandoned.
        @(negedge clk);
        s_axi_awid = 8'h90; s_axi_awaddr = 32'h3000; s_axi_awlen = 8'd3; s_axi_awvalid = 1'b1;
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        chk("mid_wready", DW'(s_axi_wready), DW'(1'b1));
        s_axi_wdata = pat(8'h90, 0); s_axi_wstrb = '1; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b1;
        mdl[8'hC0] = pat(8'h90, 0);
        @(negedge clk);
        s_axi_wvalid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_awready", DW'(s_axi_awready), DW'(1'b1));
        chk("mid_rst_wready",  DW'(s_axi_wready),  DW'(1'b0));
        chk("mid_rst_bvalid",  DW'(s_axi_bvalid),  DW'(1'b0));
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_no_b", DW'(s_axi_bvalid), DW'(1'b0));
        axi_read(8'h91, 32'h3000, 0, -1, n, lat);
        check_read(8'h91, 32'h3000, 0, n, lat, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
